// File: rtl/ccff_chain_loader_if.sv
`default_nettype none
//==============================================================================
// Module   : ccff_chain_loader_if
// Brief    : Configuration-word and readback-word valid/ready streams
//            between a configuration source and ccff_chain_loader.
// Revision : 1.0 - initial release
//==============================================================================
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] cfg_data;
    logic              rb_valid;
    logic              rb_ready;
    logic [WORD_W-1:0] rb_data;

    // The loader consumes configuration words and produces readback words.
    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  rb_ready,
        output cfg_ready,
        output rb_valid,
        output rb_data
    );

    modport master (
        output cfg_valid,
        output cfg_data,
        output rb_ready,
        input  cfg_ready,
        input  rb_valid,
        input  rb_data
    );
endinterface
`default_nettype wire

// File: rtl/ccff_chain_loader.sv
`default_nettype none
//==============================================================================
// Module   : ccff_chain_loader
// Brief    : Serialises configuration words LSB-first into a ccff chain while
//            collecting the bits leaving the chain tail as readback words.
// Revision : 1.0 - initial release
//==============================================================================
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8
) (
    input  logic               prog_clk,
    input  logic               pReset,
    input  logic               start,
    ccff_chain_loader_if.slave bus,
    output logic               ccff_head,
    output logic               ccff_shift_en,
    input  logic               ccff_tail,
    output logic               busy,
    output logic               done
);
    localparam int c_BIT_W   = $clog2(WORD_W + 1);
    localparam int c_TOTAL_W = $clog2(CHAIN_LEN + 1);

    localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(WORD_W - 1);
    localparam logic [c_TOTAL_W-1:0] c_TOTAL_LAST = c_TOTAL_W'(CHAIN_LEN - 1);
    localparam logic [c_TOTAL_W-1:0] c_TOTAL_FULL = c_TOTAL_W'(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SHIFT  = 3'd2,
        S_RBWAIT = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_BIT_W-1:0]     r_bitcnt;
    logic [c_TOTAL_W-1:0]   r_total;
    logic [WORD_W-1:0]      r_shreg;
    logic [WORD_W-1:0]      w_shreg_nxt;
    logic [WORD_W-1:0]      r_rb_data;
    logic                   r_cfg_ready;
    logic                   r_rb_valid;
    logic                   r_head;
    logic                   r_shift_en;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_cfg_hs;
    logic                   w_rb_hs;
    logic                   w_word_end;
    logic                   w_pass_end;

    assign w_cfg_hs    = bus.cfg_valid & r_cfg_ready;
    assign w_rb_hs     = r_rb_valid & bus.rb_ready;
    // Evaluated with the pre-increment counts: true on the last bit of a word.
    assign w_word_end  = (r_bitcnt == c_BIT_LAST) || (r_total == c_TOTAL_LAST);
    assign w_pass_end  = (r_total == c_TOTAL_FULL);
    assign w_shreg_nxt = r_shreg >> 1;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_cfg_hs) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_word_end) begin
                    w_state_nxt = S_RBWAIT;
                end
            end
            S_RBWAIT: begin
                if (w_rb_hs) begin
                    w_state_nxt = w_pass_end ? S_FINISH : S_FETCH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs. Strobes are decoded from the next
    // state so each one is a clean flop output aligned with its state.
    //--------------------------------------------------------------------------
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_bitcnt    <= '0;
            r_total     <= '0;
            r_shreg     <= '0;
            r_rb_data   <= '0;
            r_cfg_ready <= 1'b0;
            r_rb_valid  <= 1'b0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt == S_FETCH);
            r_shift_en  <= (w_state_nxt == S_SHIFT);
            r_rb_valid  <= (w_state_nxt == S_RBWAIT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FINISH);

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bitcnt  <= '0;
                        r_total   <= '0;
                        r_rb_data <= '0;
                        r_head    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (w_cfg_hs) begin
                        r_shreg <= bus.cfg_data;
                        r_head  <= bus.cfg_data[0];
                    end
                end
                S_SHIFT: begin
                    for (int i = 0; i < WORD_W; i++) begin
                        if (r_bitcnt == c_BIT_W'(i)) begin
                            r_rb_data[i] <= ccff_tail;
                        end
                    end
                    r_shreg  <= w_shreg_nxt;
                    r_bitcnt <= r_bitcnt + 1'b1;
                    r_total  <= r_total + 1'b1;
                    r_head   <= w_word_end ? 1'b0 : w_shreg_nxt[0];
                end
                S_RBWAIT: begin
                    // Clearing here keeps unused bits of a partial last word at 0.
                    if (w_rb_hs) begin
                        r_bitcnt  <= '0;
                        r_rb_data <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_cfg_ready;
    assign bus.rb_valid  = r_rb_valid;
    assign bus.rb_data   = r_rb_data;
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Serial configuration loader that sits directly upstream of a configuration chain (the `ccff_head` → `ccff_tail` chain through a tile's connection-block and switch-block memories). It accepts configuration words over a valid/ready stream, serialises them LSB-first onto `ccff_head`, and issues a per-bit shift enable for the chain's gated programming clock. It also captures the bits leaving `ccff_tail` and returns them as readback words, so one pass both loads new contents and reads back the previous contents.

## Interface
- `CHAIN_LEN`, default 16: number of flip-flops in the attached chain (≥1).
- `WORD_W`, default 8: configuration/readback word width (≥1).
- `NWORDS`, derived: ceil(CHAIN_LEN/WORD_W).
- `prog_clk` input 1: the single clock, rising-edge.
- `pReset` input 1: reset, asynchronous, active-low.
- `start` input 1: pulse to begin one load pass; ignored while `busy`=1.
- `cfg_valid` input 1: configuration word valid.
- `cfg_ready` output 1: loader accepts `cfg_data` this cycle.
- `cfg_data` input WORD_W: configuration word, bit 0 shifted first.
- `ccff_head` output 1: serial data into chain head (registered).
- `ccff_shift_en` output 1: chain clock-gate enable (registered); the chain shifts exactly on edges ending a cycle with this high.
- `ccff_tail` input 1: last chain bit.
- `rb_valid` output 1: readback word valid.
- `rb_ready` input 1: readback consumer ready.
- `rb_data` output WORD_W: readback word, bit 0 = first bit out of `ccff_tail`.
- `busy` output 1: pass in progress.
- `done` output 1: one-cycle pulse at pass completion.

## Operation
- States: IDLE, FETCH, SHIFT, RBWAIT, FINISH.
- IDLE: `busy`=0. `start`=1 → FETCH; word counter, bit counter and readback register cleared.
- FETCH: `cfg_ready`=1. On `cfg_valid`&&`cfg_ready`, latch `cfg_data` into the shift register → SHIFT. While waiting, `ccff_shift_en`=0.
- SHIFT: each cycle drive `ccff_head`=shreg[0] with `ccff_shift_en`=1, and sample `ccff_tail` into `rb_data`[bitcnt] at the same edge. Then shift shreg right and increment bitcnt and the total-bit count.
- The word ends when bitcnt = WORD_W, or when total bits = CHAIN_LEN (partial last word, which has CHAIN_LEN mod WORD_W bits when nonzero). At word end → RBWAIT with `rb_valid`=1.
- On a partial last word, unused upper cfg bits are discarded and unused `rb_data` bits are 0.
- RBWAIT: hold `rb_data`/`rb_valid` until `rb_ready`. On handshake: if total = CHAIN_LEN → FINISH, else → FETCH.
- FINISH: `done`=1 for one cycle → IDLE.
- No shifting occurs in any state except SHIFT. Stalls on `cfg_valid`=0 or `rb_ready`=0 therefore never corrupt chain contents.
- The chain acts as a CHAIN_LEN-deep FIFO, so readback word k of pass N equals config word k of pass N-1.
- Counter widths: bitcnt clog2(WORD_W+1), total clog2(CHAIN_LEN+1); neither wraps within a pass.

## Timing
- Reset values (async on `pReset`=0): state IDLE; `cfg_ready`, `ccff_head`, `ccff_shift_en`, `rb_valid`, `busy`, `done` all 0; `rb_data`=0.
- Reset mid-pass aborts immediately. `ccff_shift_en` drops asynchronously. Chain contents are undefined and a new pass is required.
- `start`→first `cfg_ready`: 1 cycle. Handshake→first `ccff_shift_en`: 1 cycle.
- A full word takes WORD_W consecutive shift cycles with no bubbles.
- Per word minimum: 1 fetch + WORD_W shift + 1 readback cycle.
- Minimum pass time: NWORDS·(WORD_W+2) − (NWORDS·WORD_W − CHAIN_LEN) + 1 (FINISH) cycles after `start`.
- `start` coinciding with `done` is ignored (busy still 1 in FINISH).
- `cfg_valid` asserted outside FETCH is not consumed.
- `rb_data` is stable while `rb_valid`=1.

## Test plan
- **Baseline load, CHAIN_LEN=16, WORD_W=8:** reset, `start`, words 0xA5, 0x3C → `ccff_head` during shift cycles = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. Exactly 16 `ccff_shift_en` cycles, one `done`.
- **Readback:** second pass with words 0x00, 0x00 against a behavioural 16-bit chain model → `rb_data` = 0xA5, then 0x3C; chain model then holds all zeros.
- **Partial word, CHAIN_LEN=12:** words 0xFF, 0xFF → 12 shift cycles. Second `rb_data` has bits[7:4]=0. `done` follows the second readback handshake.
- **Backpressure:** hold `cfg_valid`=0 for 5 cycles and `rb_ready`=0 for 7 cycles mid-pass → `ccff_shift_en`=0 throughout both stalls; final chain contents and readback are unchanged versus the no-stall run.
- **Start while busy:** pulse `start` during SHIFT and during FINISH → no restart; the shift count stays 16.
- **Reset mid-pass:** drop `pReset` after 5 shifts → all outputs 0 asynchronously. After release, a full pass with 0x12, 0x34 completes with 16 shifts; readback is don't-care.
